// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// slave = the controller, master = the requester driving loads/stores.
interface data_mem_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_rdata;
    logic        o_resp_err;

    modport slave (
        input  i_req_valid, i_we, i_funct3, i_addr, i_wdata, i_resp_ready,
        output o_req_ready, o_resp_valid, o_rdata, o_resp_err
    );

    modport master (
        output i_req_valid, i_we, i_funct3, i_addr, i_wdata, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_rdata, o_resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: one outstanding request, optional wait
// states, byte/half/word loads and stores with alignment/range checks.
module data_mem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    data_mem_ctrl_if.slave bus
);
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    req_t              req_q, req_in, cur;
    logic              ready_en;
    logic              accept, enter_resp;
    logic              err, misal, illegal, oor;
    logic [3:0]        be;
    logic [31:0]       wdata_sh, word_rd, shifted, load_val;
    logic [ADDR_W-3:0] widx;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Not reset: contents are undefined until written.
    logic [31:0] mem [WORDS];

    assign req_in = '{we: bus.i_we, funct3: bus.i_funct3, addr: bus.i_addr, wdata: bus.i_wdata};
    assign accept = bus.i_req_valid & bus.o_req_ready;

    // With no wait states RESP is entered on the accept edge itself, so the
    // live request must be decoded there; otherwise the captured copy is used.
    assign cur        = (state == S_IDLE) ? req_in : req_q;
    assign enter_resp = (state == S_IDLE && accept && WAIT_STATES == 0) ||
                        (state == S_WAIT && cnt == 4'd0);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP: if (bus.i_resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; ready is held off until the first edge out of reset.
    always_comb begin
        bus.o_req_ready  = (state == S_IDLE) && ready_en;
        bus.o_resp_valid = (state == S_RESP);
    end

    // Error decode: misalignment, out-of-range address, illegal size code.
    always_comb begin
        misal   = 1'b0;
        illegal = 1'b0;
        case (cur.funct3)
            3'b000, 3'b100: misal = 1'b0;
            3'b001, 3'b101: misal = cur.addr[0];
            3'b010:         misal = (cur.addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        if (cur.funct3[2:1] == 2'b10 && cur.we) illegal = 1'b1;
        oor = ((cur.addr >> ADDR_W) != 32'd0);
        err = misal | illegal | oor;
    end

    // Lane steering for stores and right-alignment/extension for loads.
    always_comb begin
        case (cur.funct3[1:0])
            2'b00:   be = 4'b0001 << cur.addr[1:0];
            2'b01:   be = 4'b0011 << cur.addr[1:0];
            default: be = 4'b1111;
        endcase
        widx     = cur.addr[ADDR_W-1:2];
        wdata_sh = cur.wdata << {cur.addr[1:0], 3'b000};
        word_rd  = mem[widx];
        shifted  = word_rd >> {cur.addr[1:0], 3'b000};
        case (cur.funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = word_rd;
        endcase
    end

    // Byte-enabled store, committed only on the edge that enters RESP.
    always_ff @(posedge i_clk) begin
        if (enter_resp && !err && cur.we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en <= 1'b0;
            req_q    <= '0;
            cnt      <= 4'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                req_q <= req_in;
                cnt   <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= err;
                rdata_q <= (err || cur.we) ? 32'd0 : load_val;
            end else if (state == S_RESP && bus.i_resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    assign bus.o_rdata    = rdata_q;
    assign bus.o_resp_err = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (0, 3 and 2 wait states) share
// one stimulus driver; sel picks which instance sees requests and is observed.
module tb_data_mem_ctrl;
    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0, we = 1'b0, resp_ready = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [31:0] addr = '0, wdata = '0;
    int          sel = 0;
    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_rdata;
    exp_t        sb[$];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus3 ();
    data_mem_ctrl_if bus2 ();

    assign bus0.i_req_valid = req_valid && sel == 0;
    assign bus0.i_we = we;  assign bus0.i_funct3 = f3;
    assign bus0.i_addr = addr;  assign bus0.i_wdata = wdata;
    assign bus0.i_resp_ready = resp_ready && sel == 0;
    assign bus3.i_req_valid = req_valid && sel == 3;
    assign bus3.i_we = we;  assign bus3.i_funct3 = f3;
    assign bus3.i_addr = addr;  assign bus3.i_wdata = wdata;
    assign bus3.i_resp_ready = resp_ready && sel == 3;
    assign bus2.i_req_valid = req_valid && sel == 2;
    assign bus2.i_we = we;  assign bus2.i_funct3 = f3;
    assign bus2.i_addr = addr;  assign bus2.i_wdata = wdata;
    assign bus2.i_resp_ready = resp_ready && sel == 2;

    data_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    data_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));
    data_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(2)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    always_comb begin
        case (sel)
            3: begin obs_ready = bus3.o_req_ready; obs_valid = bus3.o_resp_valid;
                     obs_rdata = bus3.o_rdata; obs_err = bus3.o_resp_err; end
            2: begin obs_ready = bus2.o_req_ready; obs_valid = bus2.o_resp_valid;
                     obs_rdata = bus2.o_rdata; obs_err = bus2.o_resp_err; end
            default: begin obs_ready = bus0.o_req_ready; obs_valid = bus0.o_resp_valid;
                     obs_rdata = bus0.o_rdata; obs_err = bus0.o_resp_err; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request; the expected response goes to the scoreboard first.
    // hold: cycles to keep i_resp_ready low once the response is up.
    // junk: keep i_req_valid high after accept with a different store.
    task automatic do_req(input logic w, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] x_rd, input logic x_err,
                          input int hold, input bit junk);
        exp_t e;
        int   lat;
        e.rd = x_rd; e.err = x_err;
        sb.push_back(e);
        @(negedge clk);
        we = w; f3 = fn; addr = a; wdata = d; req_valid = 1'b1;
        chk("req_ready", 32'(obs_ready), 32'd1);
        @(posedge clk); #1;
        if (junk) begin
            we = 1'b1; f3 = 3'b010; addr = a ^ 32'h40; wdata = ~d;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!obs_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(sel + 1));
        e = sb.pop_front();
        chk("rdata", obs_rdata, e.rd);
        chk("resp_err", 32'(obs_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(obs_valid), 32'd1);
            chk("hold_ready", 32'(obs_ready), 32'd0);
            chk("hold_rdata", obs_rdata, e.rd);
            chk("hold_err", 32'(obs_err), 32'(e.err));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("resp_done", 32'(obs_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_err", 32'(obs_err), 32'd0);
        chk("rst_rdata", obs_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(obs_ready), 32'd1);

        // 0 wait states: sizes, extension, lane placement
        sel = 0;
        do_req(1, 3'b010, 32'h010, 32'h8000_00F1, 32'h0, 0, 0, 0);
        do_req(0, 3'b000, 32'h010, 32'h0, 32'hFFFF_FFF1, 0, 0, 0);
        do_req(0, 3'b100, 32'h013, 32'h0, 32'h0000_0080, 0, 0, 0);
        do_req(1, 3'b010, 32'h020, 32'h5566_7788, 32'h0, 0, 0, 0);
        do_req(1, 3'b001, 32'h022, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        do_req(0, 3'b010, 32'h020, 32'h0, 32'hABCD_7788, 0, 0, 0);
        do_req(0, 3'b001, 32'h022, 32'h0, 32'hFFFF_ABCD, 0, 0, 0);
        do_req(0, 3'b101, 32'h022, 32'h0, 32'h0000_ABCD, 0, 0, 0);
        do_req(1, 3'b000, 32'h021, 32'h0000_00A5, 32'h0, 0, 0, 0);
        do_req(0, 3'b010, 32'h020, 32'h0, 32'hABCD_A588, 0, 0, 0);
        do_req(0, 3'b000, 32'h021, 32'h0, 32'hFFFF_FFA5, 0, 0, 0);

        // error cases leave memory untouched
        do_req(1, 3'b010, 32'h004, 32'h0102_0304, 32'h0, 0, 0, 0);
        do_req(0, 3'b010, 32'h006, 32'h0, 32'h0, 1, 0, 0);
        do_req(1, 3'b001, 32'h001, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        do_req(1, 3'b100, 32'h004, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        do_req(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 0, 0);
        do_req(1, 3'b010, 32'h1004, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        do_req(1, 3'b010, 32'h005, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        do_req(0, 3'b011, 32'h004, 32'h0, 32'h0, 1, 0, 0);
        do_req(1, 3'b110, 32'h004, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
        do_req(0, 3'b010, 32'h004, 32'h0, 32'h0102_0304, 0, 0, 0);
        do_req(0, 3'b001, 32'h006, 32'h0, 32'h0000_0102, 0, 0, 0);

        // request held valid outside IDLE is ignored
        do_req(1, 3'b010, 32'h07C, 32'h1111_2222, 32'h0, 0, 0, 0);
        do_req(1, 3'b010, 32'h03C, 32'h3333_4444, 32'h0, 0, 0, 0);
        do_req(0, 3'b010, 32'h07C, 32'h0, 32'h1111_2222, 0, 0, 1);
        do_req(0, 3'b010, 32'h03C, 32'h0, 32'h3333_4444, 0, 0, 0);

        // 3 wait states with a stalled consumer
        sel = 3;
        do_req(1, 3'b010, 32'h080, 32'h1357_9BDF, 32'h0, 0, 5, 0);
        do_req(0, 3'b010, 32'h080, 32'h0, 32'h1357_9BDF, 0, 5, 0);

        // 2 wait states: reset during WAIT aborts the store
        sel = 2;
        do_req(1, 3'b010, 32'h040, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
        @(negedge clk);
        we = 1'b1; f3 = 3'b010; addr = 32'h040; wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(obs_valid), 32'd0);
        chk("abort_rdata", obs_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_noresp", 32'(obs_valid), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(obs_ready), 32'd1);
        chk("abort_idle", 32'(obs_valid), 32'd0);
        do_req(0, 3'b010, 32'h040, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
